// File: rtl/spi_pkg.sv
// +----------------------------------------------------------------------+
// | spi_pkg : shared SPI types, mode constants and width helpers          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_FIN   = 3'd5
    } spi_state_e;

    localparam logic c_cpol      = 1'b0;
    localparam logic c_cpha      = 1'b0;
    localparam logic c_msb_first = 1'b1;

    // Bits needed for a counter that runs 0 .. n_states-1.
    function automatic int cnt_width(input int n_states);
        return (n_states <= 2) ? 1 : $clog2(n_states);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_joy_master_if.sv
// +----------------------------------------------------------------------+
// | spi_joy_master_if : host request/response plus SPI pin bundle         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface spi_joy_master_if #(
    parameter int NBYTES = 5
);
    logic                  START;
    logic [8*NBYTES-1:0]   TX_DATA;
    logic                  BUSY;
    logic                  DONE;
    logic [8*NBYTES-1:0]   RX_DATA;
    logic                  SCLK;
    logic                  MOSI;
    logic                  MISO;
    logic                  SS;

    modport master (
        input  START, TX_DATA, MISO,
        output BUSY, DONE, RX_DATA, SCLK, MOSI, SS
    );

    modport slave (
        output START, TX_DATA, MISO,
        input  BUSY, DONE, RX_DATA, SCLK, MOSI, SS
    );
endinterface

`default_nettype wire

// File: rtl/spi_byte_shifter.sv
// +----------------------------------------------------------------------+
// | spi_byte_shifter : 8-bit TX/RX shift pair for one SPI byte            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_byte_shifter
    import spi_pkg::*;
(
    input  wire logic       CLK,
    input  wire logic       RSTN,
    input  wire logic       i_load,
    input  wire logic [7:0] i_load_byte,
    input  wire logic       i_sample,
    input  wire logic       i_miso,
    input  wire logic       i_shift,
    output logic            o_tx_next,
    output logic [7:0]      o_rx_byte
);

    logic [7:0] r_tx;
    logic [7:0] r_rx;

    // TX rotates so the bit after the one on MOSI is always at a fixed index.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_tx <= '0;
            r_rx <= '0;
        end else if (i_load) begin
            r_tx <= i_load_byte;
            r_rx <= '0;
        end else begin
            if (i_shift) begin
                r_tx <= c_msb_first ? {r_tx[6:0], r_tx[7]} : {r_tx[0], r_tx[7:1]};
            end
            if (i_sample) begin
                r_rx <= {r_rx[6:0], i_miso};
            end
        end
    end

    assign o_tx_next = c_msb_first ? r_tx[6] : r_tx[1];
    assign o_rx_byte = r_rx;

endmodule

`default_nettype wire

// File: rtl/spi_joy_master.sv
// +----------------------------------------------------------------------+
// | spi_joy_master : mode-0 multi-byte SPI master with divided SCLK       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_joy_master
    import spi_pkg::*;
#(
    parameter int NBYTES   = 5,
    parameter int CLK_DIV  = 4,
    parameter int SS_DELAY = 10,
    parameter int BYTE_GAP = 6
) (
    input  wire logic          CLK,
    input  wire logic          RSTN,
    spi_joy_master_if.master   bus
);

    localparam int c_w     = 8 * NBYTES;
    localparam int c_cnt_w = cnt_width(max3(SS_DELAY, BYTE_GAP, CLK_DIV));
    localparam int c_byt_w = cnt_width(NBYTES);

    localparam logic [c_cnt_w-1:0] c_div_last  = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_ss_last   = c_cnt_w'(SS_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
    localparam logic [c_byt_w-1:0] c_byte_last = c_byt_w'(NBYTES - 1);

    spi_state_e           r_state,  w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt,    w_cnt_nxt;
    logic [2:0]           r_bit,    w_bit_nxt;
    logic [c_byt_w-1:0]   r_byte,   w_byte_nxt;
    logic                 r_sclk,   w_sclk_nxt;
    logic                 r_mosi,   w_mosi_nxt;
    logic                 r_ss,     w_ss_nxt;
    logic                 r_busy,   w_busy_nxt;
    logic                 r_done,   w_done_nxt;
    logic [c_w-1:0]       r_rx_data, w_rx_data_nxt;
    logic [c_w-1:0]       r_tx_rest, w_tx_rest_nxt;
    logic [c_w-1:0]       r_rx_acc,  w_rx_acc_nxt;

    logic                 w_load;
    logic [7:0]           w_load_byte;
    logic                 w_sample;
    logic                 w_shift;
    logic                 w_tx_next;
    logic [7:0]           w_rx_byte;
    logic [c_w-1:0]       w_rx_ext;

    spi_byte_shifter u_shifter (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .i_load      (w_load),
        .i_load_byte (w_load_byte),
        .i_sample    (w_sample),
        .i_miso      (bus.MISO),
        .i_shift     (w_shift),
        .o_tx_next   (w_tx_next),
        .o_rx_byte   (w_rx_byte)
    );

    always_comb begin
        w_rx_ext      = '0;
        w_rx_ext[7:0] = w_rx_byte;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_nxt     = r_bit;
        w_byte_nxt    = r_byte;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_ss_nxt      = r_ss;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_rx_data_nxt = r_rx_data;
        w_tx_rest_nxt = r_tx_rest;
        w_rx_acc_nxt  = r_rx_acc;
        w_load        = 1'b0;
        w_load_byte   = r_tx_rest[c_w-1 -: 8];
        w_sample      = 1'b0;
        w_shift       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.START) begin
                    w_state_nxt   = ST_SETUP;
                    w_cnt_nxt     = '0;
                    w_bit_nxt     = '0;
                    w_byte_nxt    = '0;
                    w_ss_nxt      = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_mosi_nxt    = bus.TX_DATA[c_w-1];
                    w_load        = 1'b1;
                    w_load_byte   = bus.TX_DATA[c_w-1 -: 8];
                    w_tx_rest_nxt = bus.TX_DATA << 8;
                    w_rx_acc_nxt  = '0;
                end
            end

            ST_SETUP: begin
                if (r_cnt == c_ss_last) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                    w_sample    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (r_cnt != c_div_last) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (r_sclk) begin
                    // Falling edge: present the next bit, or retire a finished byte.
                    w_sclk_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                    if (r_bit != 3'd7) begin
                        w_mosi_nxt = w_tx_next;
                        w_shift    = 1'b1;
                    end else begin
                        w_rx_acc_nxt = (r_rx_acc << 8) | w_rx_ext;
                        if (r_byte != c_byte_last) begin
                            w_mosi_nxt    = r_tx_rest[c_w-1];
                            w_load        = 1'b1;
                            w_tx_rest_nxt = r_tx_rest << 8;
                        end else begin
                            w_mosi_nxt = 1'b0;
                        end
                    end
                end else begin
                    w_cnt_nxt = '0;
                    if (r_bit != 3'd7) begin
                        w_bit_nxt  = r_bit + 3'd1;
                        w_sclk_nxt = 1'b1;
                        w_sample   = 1'b1;
                    end else if (r_byte != c_byte_last) begin
                        w_bit_nxt  = '0;
                        w_byte_nxt = r_byte + 1'b1;
                        if (BYTE_GAP == 0) begin
                            w_sclk_nxt = 1'b1;
                            w_sample   = 1'b1;
                        end else begin
                            w_state_nxt = ST_GAP;
                        end
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end

            ST_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                    w_sample    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_HOLD: begin
                if (r_cnt == c_div_last) begin
                    w_state_nxt = ST_FIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_FIN: begin
                w_state_nxt   = ST_IDLE;
                w_ss_nxt      = 1'b1;
                w_busy_nxt    = 1'b0;
                w_done_nxt    = 1'b1;
                w_rx_data_nxt = r_rx_acc;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_sclk    <= c_cpol;
            r_mosi    <= 1'b0;
            r_ss      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_data <= '0;
            r_tx_rest <= '0;
            r_rx_acc  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_byte    <= w_byte_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_ss      <= w_ss_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_tx_rest <= w_tx_rest_nxt;
            r_rx_acc  <= w_rx_acc_nxt;
        end
    end

    assign bus.SCLK    = r_sclk;
    assign bus.MOSI    = r_mosi;
    assign bus.SS      = r_ss;
    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;
    assign bus.RX_DATA = r_rx_data;

endmodule

`default_nettype wire
